// File: rtl/pad_poll_sequencer.sv
// Game-pad poll scheduler with an APB3 register front-end: strobes the pad's
// latch (poll) and shift clock (sample), and deserialises the returned button bits.
module pad_poll_sequencer #(
  parameter int unsigned NBITS      = 5,
  parameter logic [23:0] PERIOD_RST = 24'd1_000_000,
  parameter logic [7:0]  DIV_RST    = 8'd50
) (
  input  logic             PCLK,
  input  logic             PRESERN,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [31:0]      PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic             data,
  output logic             poll,
  output logic             sample,
  output logic [NBITS-1:0] buttonData,
  output logic             ready,
  output logic             irq
);

  localparam int unsigned IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned PER_W = 24;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = 32;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PERIOD = 3'd1;
  localparam logic [2:0] A_DIV    = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_DATA   = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] ph_q, ph_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] button_q, button_d;
  logic             poll_q, poll_d, sample_q, sample_d;
  logic             ready_q, ready_d, irq_q, irq_d;
  logic             en_q, en_d, irq_en_q, irq_en_d;
  logic [PER_W-1:0] period_q, period_d, pcnt_q, pcnt_d;
  logic [DIV_W-1:0] divreg_q, divreg_d;
  logic             done_q, done_d, ovr_q, ovr_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;

  logic [2:0]       addr_c;
  logic             wr_c, oneshot_c, wrap_c, req_c, phase_end_c;
  logic [PER_W-1:0] period_m1_c;
  logic             unused_c;

  // APB decode and scan-request sources; PERIOD of 0 wraps every cycle like 1
  assign addr_c      = PADDR[4:2];
  assign wr_c        = PSEL & PENABLE & PWRITE;
  assign oneshot_c   = wr_c && (addr_c == A_CTRL) && PWDATA[1];
  assign period_m1_c = (period_q == '0) ? '0 : period_q - PER_W'(1);
  assign wrap_c      = en_q && (pcnt_q == period_m1_c);
  assign req_c       = wrap_c | oneshot_c;
  assign phase_end_c = (ph_q == div_q - DIV_W'(1));
  assign unused_c    = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:24]};

  assign PREADY     = 1'b1;
  assign PSLVERR    = PSEL & PENABLE & (addr_c > A_DATA);
  assign poll       = poll_q;
  assign sample     = sample_q;
  assign buttonData = button_q;
  assign ready      = ready_q;
  assign irq        = irq_q;

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (addr_c)
        A_CTRL:   PRDATA = DW'({irq_en_q, 1'b0, en_q});
        A_PERIOD: PRDATA = DW'(period_q);
        A_DIV:    PRDATA = DW'(divreg_q);
        A_STATUS: PRDATA = DW'({ovr_q, done_q, state_q != S_IDLE});
        A_DATA:   PRDATA = {8'd0, scan_cnt_q, 16'(button_q)};
        default:  PRDATA = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    ph_d       = ph_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    button_d   = button_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    period_d   = period_q;
    divreg_d   = divreg_q;
    pcnt_d     = pcnt_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    scan_cnt_d = scan_cnt_q;
    poll_d     = 1'b0;
    sample_d   = 1'b0;
    ready_d    = 1'b0;
    irq_d      = 1'b0;

    if (wr_c) begin
      case (addr_c)
        A_CTRL: begin
          en_d     = PWDATA[0];
          irq_en_d = PWDATA[2];
        end
        A_PERIOD: period_d = PWDATA[PER_W-1:0];
        A_DIV:    divreg_d = PWDATA[DIV_W-1:0];
        A_STATUS: begin
          if (PWDATA[1]) done_d = 1'b0;
          if (PWDATA[2]) ovr_d  = 1'b0;
        end
        default: ;
      endcase
    end

    if (wr_c && (addr_c == A_PERIOD)) pcnt_d = '0;
    else if (!en_q || wrap_c)         pcnt_d = '0;
    else                              pcnt_d = pcnt_q + PER_W'(1);

    if (req_c && (state_q != S_IDLE)) ovr_d = 1'b1;

    // Status sets below come after the W1C clears so a same-cycle set wins
    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          state_d = S_LATCH;
          ph_d    = '0;
          div_d   = (divreg_q == '0) ? DIV_W'(1) : divreg_q;
        end
      end
      S_LATCH: begin
        if (phase_end_c) begin
          state_d = S_LOW;
          ph_d    = '0;
          idx_d   = '0;
        end else begin
          ph_d = ph_q + DIV_W'(1);
        end
      end
      S_LOW: begin
        if (phase_end_c) begin
          shift_d[idx_q] = ~data;
          ph_d           = '0;
          state_d        = (idx_q == IDX_W'(NBITS - 1)) ? S_DONE : S_HIGH;
        end else begin
          ph_d = ph_q + DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (phase_end_c) begin
          state_d = S_LOW;
          ph_d    = '0;
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          ph_d = ph_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        button_d   = shift_q;
        done_d     = 1'b1;
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    poll_d   = (state_d == S_LATCH);
    sample_d = (state_d == S_HIGH);
    ready_d  = (state_d == S_DONE);
    irq_d    = done_d & irq_en_d;
  end

  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state_q    <= S_IDLE;
      div_q      <= DIV_W'(1);
      ph_q       <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      button_q   <= '0;
      poll_q     <= 1'b0;
      sample_q   <= 1'b0;
      ready_q    <= 1'b0;
      irq_q      <= 1'b0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      period_q   <= PERIOD_RST;
      divreg_q   <= DIV_RST;
      pcnt_q     <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      scan_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ph_q       <= ph_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      button_q   <= button_d;
      poll_q     <= poll_d;
      sample_q   <= sample_d;
      ready_q    <= ready_d;
      irq_q      <= irq_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      period_q   <= period_d;
      divreg_q   <= divreg_d;
      pcnt_q     <= pcnt_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

endmodule

// File: tb/tb_pad_poll_sequencer.sv
// Bench for pad_poll_sequencer: constant register table, directed multi-cycle
// scenarios, and randomized traffic against a scan-offset reference model.
module tb_pad_poll_sequencer;

  localparam int unsigned NB = 5;

  logic          PCLK = 1'b0;
  logic          PRESERN = 1'b1;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0]   PADDR = '0, PWDATA = '0;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic          data = 1'b1;
  logic          poll, sample, ready, irq;
  logic [NB-1:0] buttonData;

  pad_poll_sequencer #(
    .NBITS(NB), .PERIOD_RST(24'd1_000_000), .DIV_RST(8'd50)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .data(data), .poll(poll),
    .sample(sample), .buttonData(buttonData), .ready(ready), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a running scan is just an offset k into a 2*d*NB+1 cycle window
  bit          m_en, m_ie, m_busy, m_done, m_ovr;
  int unsigned m_per, m_div, m_pcnt, m_k, m_d, m_cnt;
  bit [NB-1:0] m_shift, m_btn;

  bit          pat_mode = 1'b0;
  bit [NB-1:0] pat = '0;
  logic [31:0] last_rd;
  logic        last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int unsigned scan_len(input int unsigned d);
    return 2 * d * NB + 1;
  endfunction
  function automatic bit in_latch();
    return m_busy && (m_k < m_d);
  endfunction
  function automatic bit in_done();
    return m_busy && (m_k == scan_len(m_d) - 1);
  endfunction
  function automatic bit in_high();
    if (!m_busy || m_k < m_d || in_done()) return 1'b0;
    return (((m_k - m_d) / m_d) % 2) == 1;
  endfunction
  function automatic int cur_bit();
    return int'((m_k - m_d) / (2 * m_d));
  endfunction

  function automatic logic [31:0] exp_rd(input logic sel, input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    if (!sel) return r;
    case (a)
      3'd0: r = {29'd0, m_ie, 1'b0, m_en};
      3'd1: r = 32'(m_per);
      3'd2: r = 32'(m_div);
      3'd3: r = {29'd0, m_ovr, m_done, m_busy};
      3'd4: r = {8'd0, 8'(m_cnt), 16'(m_btn)};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_busy = 0; m_done = 0; m_ovr = 0;
    m_per = 1_000_000; m_div = 50; m_pcnt = 0; m_k = 0; m_d = 1; m_cnt = 0;
    m_shift = '0; m_btn = '0;
  endtask

  // Advance the model across one clock edge using the inputs held for that cycle
  task automatic model_step();
    bit          wr, wrap, req;
    logic [2:0]  a;
    int unsigned pm1, r;
    if (PRESERN) begin
      model_reset();
      return;
    end
    a    = PADDR[4:2];
    wr   = PSEL && PENABLE && PWRITE;
    pm1  = (m_per == 0) ? 0 : m_per - 1;
    wrap = m_en && (m_pcnt == pm1);
    req  = wrap || (wr && a == 3'd0 && PWDATA[1]);
    if (wr && a == 3'd3) begin
      if (PWDATA[1]) m_done = 0;
      if (PWDATA[2]) m_ovr = 0;
    end
    if (req && m_busy) m_ovr = 1;
    if (m_busy) begin
      if (in_done()) begin
        m_btn = m_shift; m_done = 1; m_cnt = (m_cnt + 1) % 256; m_busy = 0;
      end else begin
        if (m_k >= m_d) begin
          r = m_k - m_d;
          if (((r / m_d) % 2 == 0) && (r % m_d == m_d - 1)) m_shift[r / (2 * m_d)] = ~data;
        end
        m_k++;
      end
    end else if (req) begin
      m_busy = 1; m_k = 0; m_d = (m_div == 0) ? 1 : m_div;
    end
    if (wr && a == 3'd1)     m_pcnt = 0;
    else if (!m_en || wrap) m_pcnt = 0;
    else                    m_pcnt++;
    if (wr && a == 3'd0) begin m_en = PWDATA[0]; m_ie = PWDATA[2]; end
    if (wr && a == 3'd1) m_per = 32'(PWDATA[23:0]);
    if (wr && a == 3'd2) m_div = 32'(PWDATA[7:0]);
  endtask

  task automatic tick();
    if (pat_mode) data = (m_busy && m_k >= m_d && !in_done()) ? pat[cur_bit()] : 1'b1;
    else          data = 1'($urandom);
    @(negedge PCLK);
    last_rd  = PRDATA;
    last_err = PSLVERR;
    chk("PRDATA", PRDATA, exp_rd(PSEL, PADDR[4:2]));
    chk("PSLVERR", 32'(PSLVERR), 32'(PSEL && PENABLE && (PADDR[4:2] >= 3'd5)));
    @(posedge PCLK);
    model_step();
    cyc++;
    #1;
    chk("poll", 32'(poll), 32'(in_latch()));
    chk("sample", 32'(sample), 32'(in_high()));
    chk("ready", 32'(ready), 32'(in_done()));
    chk("irq", 32'(irq), 32'(m_done && m_ie));
    chk("buttonData", 32'(buttonData), 32'(m_btn));
    chk("PREADY", 32'(PREADY), 32'd1);
  endtask

  task automatic apb_idle();
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_write(input logic [2:0] idx, input logic [31:0] val);
    PSEL = 1; PENABLE = 0; PWRITE = 1;
    PADDR = {27'($urandom), idx, 2'($urandom)};
    PWDATA = val;
    tick();
    PENABLE = 1;
    tick();
    apb_idle();
  endtask

  task automatic apb_read(input logic [2:0] idx, output logic [31:0] val, output logic err);
    PSEL = 1; PENABLE = 0; PWRITE = 0;
    PADDR = {27'($urandom), idx, 2'($urandom)};
    tick();
    PENABLE = 1;
    tick();
    val = last_rd;
    err = last_err;
    apb_idle();
  endtask

  task automatic wait_ready(input int start, output int len, output int npoll, output int nsamp);
    len = start; npoll = int'(poll); nsamp = int'(sample);
    while (ready !== 1'b1 && len < 500) begin
      tick();
      len++;
      npoll += int'(poll);
      nsamp += int'(sample);
    end
    chk("ready_seen", 32'(ready), 32'd1);
  endtask

  task automatic ready_gaps(input int ncyc, output int npulse, output int last_gap);
    int prev;
    prev = -1; npulse = 0; last_gap = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (ready === 1'b1) begin
        if (prev >= 0) last_gap = cyc - prev;
        prev = cyc;
        npulse++;
      end
    end
  endtask

  function automatic logic [31:0] rand_val(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'($urandom_range(0, 7));
      3'd1:    return 32'($urandom_range(0, 40));
      3'd2:    return 32'($urandom_range(0, 3));
      3'd3:    return 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic        psel;
    logic        pen;
    logic [2:0]  idx;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] v;
    logic        e;
    int          len, np, ns, npulse, gap;

    vecs[0] = '{1'b1, 1'b1, 3'd0, 32'd0,         1'b0};
    vecs[1] = '{1'b1, 1'b1, 3'd1, 32'd1_000_000, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 3'd2, 32'd50,        1'b0};
    vecs[3] = '{1'b1, 1'b1, 3'd3, 32'd0,         1'b0};
    vecs[4] = '{1'b1, 1'b1, 3'd4, 32'd0,         1'b0};
    vecs[5] = '{1'b1, 1'b1, 3'd5, 32'd0,         1'b1};
    vecs[6] = '{1'b1, 1'b1, 3'd6, 32'd0,         1'b1};
    vecs[7] = '{1'b1, 1'b1, 3'd7, 32'd0,         1'b1};
    vecs[8] = '{1'b0, 1'b0, 3'd1, 32'd0,         1'b0};
    vecs[9] = '{1'b1, 1'b0, 3'd6, 32'd0,         1'b0};

    model_reset();
    PRESERN = 1;
    tick();
    tick();
    PRESERN = 0;
    chk("reset_strobes", 32'({poll, sample, ready, irq}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      PSEL = vecs[i].psel; PENABLE = vecs[i].pen; PWRITE = 0;
      PADDR = {27'($urandom), vecs[i].idx, 2'b00};
      tick();
      chk($sformatf("table%0d_rdata", i), last_rd, vecs[i].exp_rd);
      chk($sformatf("table%0d_err", i), 32'(last_err), 32'(vecs[i].exp_err));
    end
    apb_idle();

    // One-shot scan with a fixed data pattern (data bits 0..4 = 0,1,1,0,1)
    pat_mode = 1;
    pat = 5'b10110;
    apb_write(3'd2, 32'd2);
    apb_write(3'd0, 32'h6);
    wait_ready(1, len, np, ns);
    chk("oneshot_latency", 32'(len), 32'd21);
    chk("oneshot_poll_cycles", 32'(np), 32'd2);
    chk("oneshot_sample_cycles", 32'(ns), 32'd8);
    tick();
    chk("oneshot_buttons", 32'(buttonData), 32'h09);
    chk("oneshot_irq", 32'(irq), 32'd1);
    apb_read(3'd3, v, e);
    chk("oneshot_status", v, 32'h2);
    apb_read(3'd4, v, e);
    chk("oneshot_scan_cnt", 32'(v[23:16]), 32'd1);

    // Unmapped read error and W1C of DONE/OVERRUN
    apb_read(3'd6, v, e);
    chk("unmapped_err", 32'(e), 32'd1);
    chk("unmapped_rdata", v, 32'd0);
    apb_write(3'd3, 32'h6);
    chk("w1c_irq_fall", 32'(irq), 32'd0);
    apb_read(3'd3, v, e);
    chk("w1c_status", v, 32'd0);

    // DIV written mid-scan applies only to the following scan
    apb_write(3'd0, 32'h6);
    apb_write(3'd2, 32'd5);
    wait_ready(3, len, np, ns);
    chk("reconf_old_len", 32'(len), 32'd21);
    repeat (3) tick();
    apb_write(3'd0, 32'h6);
    wait_ready(1, len, np, ns);
    chk("reconf_new_len", 32'(len), 32'd51);
    chk("reconf_poll_cycles", 32'(np), 32'd5);
    pat_mode = 0;

    // Periodic scanning, then overrun when the scan outlasts the period
    apb_write(3'd2, 32'd2);
    apb_write(3'd1, 32'd30);
    apb_write(3'd3, 32'h6);
    apb_write(3'd0, 32'h1);
    ready_gaps(130, npulse, gap);
    chk("period30_pulses", 32'(npulse), 32'd3);
    chk("period30_gap", 32'(gap), 32'd30);
    apb_write(3'd1, 32'd25);
    ready_gaps(130, npulse, gap);
    chk("period25_gap", 32'(gap), 32'd25);
    apb_read(3'd3, v, e);
    chk("period25_no_ovr", 32'(v[2]), 32'd0);
    apb_write(3'd2, 32'd8);
    apb_write(3'd1, 32'd15);
    ready_gaps(400, npulse, gap);
    chk("div8_gap", 32'(gap), 32'd90);
    apb_read(3'd3, v, e);
    chk("div8_ovr", 32'(v[2]), 32'd1);
    apb_write(3'd0, 32'h0);
    for (int i = 0; i < 100 && m_busy; i++) tick();
    apb_write(3'd3, 32'h6);

    // Reset asserted while the shift clock is high
    apb_write(3'd2, 32'd2);
    apb_write(3'd0, 32'h2);
    for (int i = 0; i < 100 && !(in_high() && cur_bit() == 2); i++) tick();
    chk("midreset_sample_before", 32'(sample), 32'd1);
    PRESERN = 1;
    tick();
    chk("midreset_sample", 32'(sample), 32'd0);
    chk("midreset_ready", 32'(ready), 32'd0);
    chk("midreset_buttons", 32'(buttonData), 32'd0);
    PRESERN = 0;
    apb_read(3'd3, v, e);
    chk("midreset_status", v, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 700; i++) begin
      int unsigned op;
      logic [2:0]  idx;
      op  = $urandom_range(0, 99);
      idx = 3'($urandom_range(0, 7));
      if (op < 2) begin
        PRESERN = 1;
        tick();
        PRESERN = 0;
      end else if (op < 35) begin
        apb_write(idx, rand_val(idx));
      end else if (op < 55) begin
        apb_read(idx, v, e);
      end else begin
        repeat ($urandom_range(1, 8)) tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
